// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package mem_pkg;

   localparam int unsigned ADDR_W_DEF   = 16;
   localparam int unsigned READ_LAT_DEF = 1;
   localparam int unsigned DATA_W       = 32;
   localparam int unsigned STRB_W       = 4;
   localparam int unsigned CNT_W        = 3;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_LDR  = 1'b1
   } owner_e;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   // Command presented to the BRAM port in a grant cycle (address kept separate: it is parameterised).
   typedef struct packed {
      logic              en;
      logic [STRB_W-1:0] we;
      logic [DATA_W-1:0] din;
   } bram_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: combinational pick, registered last owner.
module rr_arb2
   import mem_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic core_req_i,
   input  logic ldr_req_i,
   output logic core_pick_o,
   output logic ldr_pick_o
);

   owner_e last_q;
   owner_e last_d;

   // On a tie the requester that did not win last time takes the port.
   always_comb begin
      core_pick_o = 1'b0;
      ldr_pick_o  = 1'b0;
      last_d      = last_q;
      if (en_i) begin
         if (core_req_i && ldr_req_i) begin
            if (last_q == OWN_LDR) begin
               core_pick_o = 1'b1;
            end else begin
               ldr_pick_o = 1'b1;
            end
         end else begin
            core_pick_o = core_req_i;
            ldr_pick_o  = ldr_req_i;
         end
         if (core_pick_o) begin
            last_d = OWN_CORE;
         end else if (ldr_pick_o) begin
            last_d = OWN_LDR;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= OWN_LDR;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory BRAM port between the core MEM stage and the program loader,
// sequencing BRAM read latency and stalling the core while it waits.
module dmem_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned READ_LAT = READ_LAT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   input  logic [STRB_W-1:0] core_wstrb,
   output logic              core_gnt,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_rvalid,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_gnt,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ldr_rvalid,
   output logic              mem_en,
   output logic [STRB_W-1:0] mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              stall_m
);

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] core_hold_q, core_hold_d;
   logic [DATA_W-1:0] ldr_hold_q, ldr_hold_d;
   bram_cmd_t         cmd;
   logic              arb_en;
   logic              core_pick;
   logic              ldr_pick;

   // Grants only happen in IDLE and never while reset is held.
   assign arb_en = rst_n && (state_q == IDLE);

   rr_arb2 u_rr_arb2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (arb_en),
      .core_req_i  (core_req),
      .ldr_req_i   (ldr_req),
      .core_pick_o (core_pick),
      .ldr_pick_o  (ldr_pick)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      core_hold_d = core_hold_q;
      ldr_hold_d  = ldr_hold_q;
      cmd         = '0;
      mem_addr    = '0;
      core_gnt    = 1'b0;
      ldr_gnt     = 1'b0;
      core_rvalid = 1'b0;
      ldr_rvalid  = 1'b0;
      core_rdata  = core_hold_q;
      ldr_rdata   = ldr_hold_q;

      case (state_q)
         IDLE: begin
            core_gnt = core_pick;
            ldr_gnt  = ldr_pick;
            if (core_pick) begin
               cmd.en   = 1'b1;
               cmd.we   = core_we ? core_wstrb : '0;
               cmd.din  = core_wdata;
               mem_addr = core_addr;
               if (!core_we) begin
                  state_d = WAIT;
                  owner_d = OWN_CORE;
                  cnt_d   = CNT_W'(READ_LAT);
               end
            end else if (ldr_pick) begin
               cmd.en   = 1'b1;
               cmd.we   = ldr_we ? '1 : '0;
               cmd.din  = ldr_wdata;
               mem_addr = ldr_addr;
               if (!ldr_we) begin
                  state_d = WAIT;
                  owner_d = OWN_LDR;
                  cnt_d   = CNT_W'(READ_LAT);
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            // Last wait cycle: BRAM data is valid now, forward it and keep a copy.
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               if (owner_q == OWN_CORE) begin
                  core_rvalid = 1'b1;
                  core_rdata  = mem_dout;
                  core_hold_d = mem_dout;
               end else begin
                  ldr_rvalid  = 1'b1;
                  ldr_rdata   = mem_dout;
                  ldr_hold_d  = mem_dout;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      stall_m = rst_n && ((core_req && !core_gnt) ||
                          ((state_q == WAIT) && (owner_q == OWN_CORE) && !core_rvalid));
   end

   assign mem_en  = cmd.en;
   assign mem_we  = cmd.we;
   assign mem_din = cmd.din;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= OWN_CORE;
         cnt_q       <= '0;
         core_hold_q <= '0;
         ldr_hold_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         core_hold_q <= core_hold_d;
         ldr_hold_q  <= ldr_hold_d;
      end
   end

endmodule
